// File: rtl/ie_branch_unit.sv
// ie_branch_unit
// ---------------------------------------------------------------------------
// Executes the IE branch/jump encodings: conditional branches 0x04..0x0B
// (BCC, BCS, BEQ, BMI, BNE, BPL, BVC, BVS) and JMP 0x1C (absolute or indirect).
// Cycle timing follows the 6502:
//   - a branch costs one extra cycle when taken
//   - it costs one more cycle when the target lands on another page
// JMP indirect fetches the 16-bit vector through a simple read handshake.
// The pointer low byte wraps inside its page, as on the original CPU.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   start              request pulse, accepted only while busy=0
//   opcode, jmp_ind    operation code and JMP addressing mode
//   op_lo, op_hi       branch offset / JMP address or pointer bytes
//   flag_c/z/n/v       processor flags
//   pc_in              address of the instruction after the branch
//   mem_rd_req/addr    vector read request and address (JMP indirect)
//   mem_rd_data/valid  vector read data, valid for one cycle
//   busy               operation in progress
//   done               one-cycle completion pulse
//   pc_load, pc_out    new PC and its load strobe
//   taken, err         branch taken / unsupported opcode, valid with done
// ---------------------------------------------------------------------------
module ie_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic              jmp_ind,
  input  logic [7:0]        op_lo,
  input  logic [7:0]        op_hi,
  input  logic              flag_c,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_v,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              busy,
  output logic              done,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic              taken,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_TAKEN, S_PAGEFIX, S_RD_LO, S_RD_HI, S_DONE
  } state_t;

  state_t state, next_state;

  logic [OP_W-1:0]   op_q;
  logic              ind_q;
  logic [7:0]        lo_q, hi_q, rd_lo_q;
  logic              c_q, z_q, n_q, v_q;
  logic [ADDR_W-1:0] pc_in_q;

  logic [ADDR_W-1:0] target;
  logic              page_cross;
  logic [7:0]        ptr_lo_inc;
  logic              is_branch, cond;

  logic              latch_ops, capture_lo;
  logic              nx_done, nx_pc_load, nx_taken, nx_err;
  logic [ADDR_W-1:0] nx_pc;

  // Branch target arithmetic on the latched operands.
  // The pointer increment stays 8 bits wide, so it wraps within the page.
  assign target     = pc_in_q + {{(ADDR_W-8){lo_q[7]}}, lo_q};
  assign page_cross = (target[ADDR_W-1:8] != pc_in_q[ADDR_W-1:8]);
  assign ptr_lo_inc = lo_q + 8'd1;

  // Decode the branch condition from the latched opcode and flags.
  always_comb begin
    is_branch = 1'b1;
    cond      = 1'b0;
    case (op_q)
      8'h04:   cond = !c_q;
      8'h05:   cond = c_q;
      8'h06:   cond = z_q;
      8'h07:   cond = n_q;
      8'h08:   cond = !z_q;
      8'h09:   cond = !n_q;
      8'h0A:   cond = !v_q;
      8'h0B:   cond = v_q;
      default: is_branch = 1'b0;
    endcase
  end

  // Next-state logic.
  // It also computes the values loaded into the registered completion
  // pulses on the edge that enters S_DONE.
  always_comb begin
    next_state = state;
    latch_ops  = 1'b0;
    capture_lo = 1'b0;
    nx_done    = 1'b0;
    nx_pc_load = 1'b0;
    nx_taken   = 1'b0;
    nx_err     = 1'b0;
    nx_pc      = pc_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_EVAL;
          latch_ops  = 1'b1;
        end
      end
      S_EVAL: begin
        if (is_branch) begin
          if (cond) begin
            next_state = S_TAKEN;
          end else begin
            next_state = S_DONE;
            nx_done    = 1'b1;
          end
        end else if (op_q == 8'h1C) begin
          if (ind_q) begin
            next_state = S_RD_LO;
          end else begin
            next_state = S_DONE;
            nx_done    = 1'b1;
            nx_pc_load = 1'b1;
            nx_taken   = 1'b1;
            nx_pc      = {hi_q, lo_q};
          end
        end else begin
          next_state = S_DONE;
          nx_done    = 1'b1;
          nx_err     = 1'b1;
        end
      end
      S_TAKEN: begin
        if (page_cross) begin
          next_state = S_PAGEFIX;
        end else begin
          next_state = S_DONE;
          nx_done    = 1'b1;
          nx_pc_load = 1'b1;
          nx_taken   = 1'b1;
          nx_pc      = target;
        end
      end
      S_PAGEFIX: begin
        next_state = S_DONE;
        nx_done    = 1'b1;
        nx_pc_load = 1'b1;
        nx_taken   = 1'b1;
        nx_pc      = target;
      end
      S_RD_LO: begin
        if (mem_rd_valid) begin
          next_state = S_RD_HI;
          capture_lo = 1'b1;
        end
      end
      S_RD_HI: begin
        if (mem_rd_valid) begin
          next_state = S_DONE;
          nx_done    = 1'b1;
          nx_pc_load = 1'b1;
          nx_taken   = 1'b1;
          nx_pc      = {mem_rd_data, rd_lo_q};
        end
      end
      S_DONE: begin
        // A new request may be accepted in the completion cycle.
        if (start) begin
          next_state = S_EVAL;
          latch_ops  = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Read handshake outputs.
  // The second address keeps the pointer high byte (6502 page-wrap quirk).
  always_comb begin
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    if (state == S_RD_LO) begin
      mem_rd_req = 1'b1;
      mem_addr   = {hi_q, lo_q};
    end else if (state == S_RD_HI) begin
      mem_rd_req = 1'b1;
      mem_addr   = {hi_q, ptr_lo_inc};
    end
  end

  // busy drops in S_DONE, so it falls in the same cycle done rises.
  assign busy = (state != S_IDLE) && (state != S_DONE);

  // State, operand latches and registered completion outputs.
  // Reset abandons any operation without issuing done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      ind_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      pc_in_q <= '0;
      rd_lo_q <= '0;
      done    <= 1'b0;
      pc_load <= 1'b0;
      taken   <= 1'b0;
      err     <= 1'b0;
      pc_out  <= '0;
    end else begin
      state   <= next_state;
      done    <= nx_done;
      pc_load <= nx_pc_load;
      taken   <= nx_taken;
      err     <= nx_err;
      pc_out  <= nx_pc;
      if (latch_ops) begin
        op_q    <= opcode;
        ind_q   <= jmp_ind;
        lo_q    <= op_lo;
        hi_q    <= op_hi;
        c_q     <= flag_c;
        z_q     <= flag_z;
        n_q     <= flag_n;
        v_q     <= flag_v;
        pc_in_q <= pc_in;
      end
      if (capture_lo) begin
        rd_lo_q <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ie_branch_unit.sv
// tb_ie_branch_unit
// Directed bench for ie_branch_unit.
// A behavioural model derives the latency and results of each operation.
// A single per-cycle process checks the DUT against it and also plays the
// memory for JMP indirect.
module tb_ie_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic        jmp_ind;
  logic [7:0]  op_lo, op_hi;
  logic        flag_c, flag_z, flag_n, flag_v;
  logic [15:0] pc_in;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_rd_valid;
  logic        busy, done, pc_load, taken, err;
  logic [15:0] pc_out;

  ie_branch_unit #(.ADDR_W(16), .OP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .jmp_ind(jmp_ind),
    .op_lo(op_lo), .op_hi(op_hi), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .pc_in(pc_in),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .busy(busy), .done(done), .pc_load(pc_load),
    .pc_out(pc_out), .taken(taken), .err(err)
  );

  always #5 clk = ~clk;

  // Counts rising edges; read at negedges it names the edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Expectation for the operation in flight.
  bit          active = 1'b0;
  int          e0, done_cyc;
  logic        exp_pcl, exp_tk, exp_err, exp_ind;
  logic [15:0] exp_pc;
  logic [15:0] exp_addr [2];
  int          rd_idx = 0;
  int          cnt = 0;
  int          mem_lat = 2;
  bit          stray = 1'b0;

  logic [7:0] mem [logic [15:0]];

  function automatic logic [7:0] memRead(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model of one operation.
  // lat is the number of edges after the start edge at which done appears.
  function automatic void modelOp(input logic [7:0] op, input logic ind,
                                  input logic [7:0] lo, input logic [7:0] hi,
                                  input logic [3:0] cznv, input logic [15:0] pc,
                                  output int lat, output logic pcl, output logic tk,
                                  output logic er, output logic [15:0] npc);
    int off, tgt;
    logic c, z, n, v;
    bit isBr, cond;
    {c, z, n, v} = cznv;
    lat = 1; pcl = 1'b0; tk = 1'b0; er = 1'b0; npc = 16'h0000;
    isBr = 1'b1; cond = 1'b0;
    case (op)
      8'h04: cond = (c == 1'b0);
      8'h05: cond = (c == 1'b1);
      8'h06: cond = (z == 1'b1);
      8'h07: cond = (n == 1'b1);
      8'h08: cond = (z == 1'b0);
      8'h09: cond = (n == 1'b0);
      8'h0A: cond = (v == 1'b0);
      8'h0B: cond = (v == 1'b1);
      default: isBr = 1'b0;
    endcase
    if (isBr) begin
      off = (lo < 8'd128) ? int'(lo) : int'(lo) - 256;
      tgt = (int'(pc) + off + 65536) % 65536;
      if (cond) begin
        tk = 1'b1; pcl = 1'b1; npc = tgt[15:0];
        lat = ((tgt / 256) != (int'(pc) / 256)) ? 3 : 2;
      end
    end else if (op == 8'h1C) begin
      tk = 1'b1; pcl = 1'b1;
      if (!ind) begin
        npc = {hi, lo};
      end else begin
        // One evaluation edge, then each vector read takes mem_lat edges.
        lat = 1 + 2 * mem_lat;
        npc = {memRead({hi, lo + 8'd1}), memRead({hi, lo})};
      end
    end else begin
      er = 1'b1;
    end
  endfunction

  // Per-cycle compare process and memory responder.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0; cnt = 0; rd_idx = 0; mem_rd_valid = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset pc_load", pc_load, 0);
        checkOutput("reset taken", taken, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset pc_out", pc_out, 0);
        checkOutput("reset mem_rd_req", mem_rd_req, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
      end else begin
        mem_rd_valid = 1'b0;
        if (active && cyc >= e0) begin
          if (cyc < done_cyc) begin
            checkOutput("busy during op", busy, 1);
            checkOutput("early done", done, 0);
            checkOutput("mem_rd_req during op", mem_rd_req, exp_ind && (cyc > e0));
          end else begin
            checkOutput("done pulse", done, 1);
            checkOutput("busy at done", busy, 0);
            checkOutput("pc_load", pc_load, exp_pcl);
            checkOutput("taken", taken, exp_tk);
            checkOutput("err", err, exp_err);
            checkOutput("mem_rd_req at done", mem_rd_req, 0);
            if (exp_pcl) checkOutput("pc_out", pc_out, exp_pc);
            active = 1'b0;
          end
        end else if (!active) begin
          checkOutput("idle done", done, 0);
          checkOutput("idle busy", busy, 0);
          checkOutput("idle mem_rd_req", mem_rd_req, 0);
        end
        if (mem_rd_req) begin
          if (rd_idx < 2) checkOutput("mem_addr", mem_addr, exp_addr[rd_idx]);
          else checkOutput("extra read request", mem_rd_req, 0);
          cnt++;
          if (cnt >= mem_lat) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = memRead(mem_addr);
            rd_idx++;
            cnt = 0;
          end
        end
        if (stray) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = 8'h5A;
          stray = 1'b0;
        end
      end
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (active && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (active) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: done not seen, got none within 60 cycles, expected cycle %0d", name, done_cyc);
      active = 1'b0;
    end
  endtask

  // Arms the expectation and pulses start.
  // Inputs are scrambled right after the start edge so they must be latched.
  task automatic launchOp(input logic [7:0] op, input logic ind, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [3:0] cznv, input logic [15:0] pc);
    int mLat;
    logic mPcl, mTk, mErr;
    logic [15:0] mPc;
    modelOp(op, ind, lo, hi, cznv, pc, mLat, mPcl, mTk, mErr, mPc);
    opcode = op; jmp_ind = ind; op_lo = lo; op_hi = hi;
    {flag_c, flag_z, flag_n, flag_v} = cznv;
    pc_in = pc;
    start = 1'b1;
    exp_pcl = mPcl; exp_tk = mTk; exp_err = mErr; exp_pc = mPc;
    exp_ind = (op == 8'h1C) && ind;
    exp_addr[0] = {hi, lo};
    exp_addr[1] = {hi, lo + 8'd1};
    rd_idx = 0; cnt = 0;
    e0 = cyc + 1;
    done_cyc = e0 + mLat;
    active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode = 8'h1C; jmp_ind = ~ind; op_lo = ~lo; op_hi = ~hi;
    {flag_c, flag_z, flag_n, flag_v} = ~cznv;
    pc_in = ~pc;
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] op, input logic ind,
                               input logic [7:0] lo, input logic [7:0] hi,
                               input logic [3:0] cznv, input logic [15:0] pc,
                               input int litLat, input logic litPcl, input logic litTk,
                               input logic litErr, input logic [15:0] litPc);
    int mLat;
    logic mPcl, mTk, mErr;
    logic [15:0] mPc;
    modelOp(op, ind, lo, hi, cznv, pc, mLat, mPcl, mTk, mErr, mPc);
    checkOutput({name, " model latency"}, mLat, litLat);
    checkOutput({name, " model pc_load"}, mPcl, litPcl);
    checkOutput({name, " model taken"}, mTk, litTk);
    checkOutput({name, " model err"}, mErr, litErr);
    if (litPcl) checkOutput({name, " model pc"}, mPc, litPc);
    waitIdle({name, " pre"});
    launchOp(op, ind, lo, hi, cznv, pc);
    waitIdle(name);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; opcode = 8'h00; jmp_ind = 1'b0;
    op_lo = 8'h00; op_hi = 8'h00; pc_in = 16'h0000;
    {flag_c, flag_z, flag_n, flag_v} = 4'b0000;
    mem[16'h02FF] = 8'h34;
    mem[16'h0200] = 8'h12;
    mem[16'h0300] = 8'h99;
    mem[16'h0310] = 8'hAA;
    mem[16'h0311] = 8'hBB;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    //              name       op     ind  lo     hi     cznv     pc        lat pcl tk er pc
    applyStimulus("BEQ cross", 8'h06, 1'b0, 8'h20, 8'h00, 4'b0100, 16'h80F0, 3, 1, 1, 0, 16'h8110);
    applyStimulus("BNE not",   8'h08, 1'b0, 8'h10, 8'h00, 4'b0100, 16'h1234, 1, 0, 0, 0, 16'h0000);
    applyStimulus("BMI back",  8'h07, 1'b0, 8'h80, 8'h00, 4'b0010, 16'h8000, 3, 1, 1, 0, 16'h7F80);
    applyStimulus("BPL same",  8'h09, 1'b0, 8'hFE, 8'h00, 4'b0000, 16'h8010, 2, 1, 1, 0, 16'h800E);
    applyStimulus("JMP ind",   8'h1C, 1'b1, 8'hFF, 8'h02, 4'b0000, 16'h0000, 5, 1, 1, 0, 16'h1234);
    applyStimulus("bad op",    8'h10, 1'b0, 8'h00, 8'h00, 4'b1111, 16'h5555, 1, 0, 0, 1, 16'h0000);
    applyStimulus("JMP abs",   8'h1C, 1'b0, 8'h00, 8'hC0, 4'b0000, 16'h0000, 1, 1, 1, 0, 16'hC000);
    applyStimulus("BCC not",   8'h04, 1'b0, 8'h10, 8'h00, 4'b1000, 16'h4000, 1, 0, 0, 0, 16'h0000);
    applyStimulus("BVS same",  8'h0B, 1'b0, 8'h01, 8'h00, 4'b0001, 16'h10FE, 2, 1, 1, 0, 16'h10FF);
    applyStimulus("BVC cross", 8'h0A, 1'b0, 8'h01, 8'h00, 4'b0000, 16'h10FF, 3, 1, 1, 0, 16'h1100);

    // Abort a JMP indirect in its second read, then send a stray valid.
    waitIdle("abort pre");
    launchOp(8'h1C, 1'b1, 8'h10, 8'h03, 4'b0000, 16'h0000);
    for (int n = 0; n < 20 && rd_idx < 1; n++) @(negedge clk);
    checkOutput("abort reached RD_HI", rd_idx, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    stray = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus("BCS after reset", 8'h05, 1'b0, 8'h05, 8'h00, 4'b1000, 16'h2000, 2, 1, 1, 0, 16'h2005);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
